jtbubl_vtiming_rx: RTL and testbench

Receiving end of the video timing interface: consumes the pixel enable and the LHBL/LVBL/HS/VS strobes and reconstructs the pixel/line position. It measures line and frame geometry and raises `locked` once the geometry is stable. It sits downstream of the video timer and feeds scan-doubler/OSD logic and the verification bench's geometry checks.

---
 rtl/jtbubl_vtiming_rx.sv | 162 ++++++++++++++++
 tb/tb_jtbubl_vtiming_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_vtiming_rx.sv
// Video timing receiver: rebuilds pixel/line position from the
// blanking/sync strobes, measures geometry and flags a stable lock.
`timescale 1ns/1ps
module jtbubl_vtiming_rx #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       HS,
    input  logic       VS,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic [8:0] htotal,
    output logic [8:0] hactive,
    output logic [8:0] vtotal,
    output logic [8:0] vactive,
    output logic [8:0] hs_pos,
    output logic [8:0] vs_line,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked
);

    localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

    logic        lhbl_q, hs_q, vs_q, lvbl_line;
    logic [8:0]  hc, vc;
    logic        hvalid, vvalid, hovf, vovf, hstable;
    logic [2:0]  match;
    logic [35:0] snap;

    logic        lhbl_rise, lhbl_fall, hs_rise, vs_rise;
    logic        v_start, v_fall, v_step;
    logic        h_sat, v_sat, h_over, v_over, h_change;
    logic [8:0]  hc_inc, vc_inc, hc_nxt, vc_nxt, htotal_nxt;
    logic [35:0] snap_nxt;

    assign lhbl_rise = pxl_cen & LHBL & ~lhbl_q;
    assign lhbl_fall = pxl_cen & ~LHBL & lhbl_q;
    assign hs_rise   = pxl_cen & HS & ~hs_q;
    assign vs_rise   = pxl_cen & VS & ~vs_q;

    // Vertical decisions are only taken at the start of each line
    assign v_start = lhbl_rise & LVBL & ~lvbl_line;
    assign v_fall  = lhbl_rise & ~LVBL & lvbl_line;
    assign v_step  = lhbl_rise & ~v_start;

    assign h_sat  = &hc;
    assign v_sat  = &vc;
    assign hc_inc = h_sat ? hc : hc + 9'd1;
    assign vc_inc = v_sat ? vc : vc + 9'd1;

    // Overflow events fire once, on the clock the flag gets set
    assign h_over = pxl_cen & ~lhbl_rise & h_sat & ~hovf;
    assign v_over = v_step & v_sat & ~vovf;

    assign h_change   = lhbl_rise & hvalid & (hc_inc != htotal);
    assign htotal_nxt = (lhbl_rise & hvalid) ? hc_inc : htotal;
    // Frame snapshot sees the line length latched on this same cen
    assign snap_nxt   = {htotal_nxt, hactive, vc_inc, vactive};

    assign hcnt   = hc;
    assign vcnt   = vc;
    assign locked = (match == LOCK_N);

    // Next pixel and line counter values
    always_comb begin
        hc_nxt = hc;
        vc_nxt = vc;
        if (pxl_cen) hc_nxt = lhbl_rise ? 9'd0 : hc_inc;
        if (v_start)     vc_nxt = 9'd0;
        else if (v_step) vc_nxt = vc_inc;
    end

    // Previous-sample registers for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            lvbl_line <= 1'b0;
        end else if (pxl_cen) begin
            lhbl_q <= LHBL;
            hs_q   <= HS;
            vs_q   <= VS;
            if (lhbl_rise) lvbl_line <= LVBL;
        end
    end

    // Horizontal counter and line measurements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc         <= 9'd0;
            hovf       <= 1'b0;
            hvalid     <= 1'b0;
            htotal     <= 9'd0;
            hactive    <= 9'd0;
            hs_pos     <= 9'd0;
            line_start <= 1'b0;
        end else begin
            hc         <= hc_nxt;
            line_start <= lhbl_rise;
            if (lhbl_rise)   hovf <= 1'b0;
            else if (h_over) hovf <= 1'b1;
            if (lhbl_rise) begin
                htotal <= htotal_nxt;
                hvalid <= 1'b1;
            end
            if (lhbl_fall & hvalid) hactive <= hc_inc;
            if (hs_rise) hs_pos <= hc_nxt;
        end
    end

    // Vertical counter and frame measurements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vc          <= 9'd0;
            vovf        <= 1'b0;
            vvalid      <= 1'b0;
            vtotal      <= 9'd0;
            vactive     <= 9'd0;
            vs_line     <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            vc          <= vc_nxt;
            frame_start <= v_start;
            if (v_start)     vovf <= 1'b0;
            else if (v_over) vovf <= 1'b1;
            if (v_start) begin
                vvalid <= 1'b1;
                if (vvalid) vtotal <= vc_inc;
            end
            if (v_fall & vvalid) vactive <= vc_inc;
            if (vs_rise) vs_line <= vc_nxt;
        end
    end

    // Lock tracking: count consecutive identical frame snapshots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match   <= 3'd0;
            snap    <= 36'd0;
            hstable <= 1'b1;
        end else begin
            if (h_over | v_over) begin
                match <= 3'd0;
            end else if (v_start & vvalid) begin
                if (hstable & ~h_change & (snap_nxt == snap))
                    match <= locked ? match : match + 3'd1;
                else
                    match <= 3'd0;
                snap <= snap_nxt;
            end
            if (v_start & vvalid) hstable <= 1'b1;
            else if (h_change)    hstable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtbubl_vtiming_rx.sv
// Bench for jtbubl_vtiming_rx: pattern generator, frame-level
// reference model checked every clock, plus literal spot checks.
`timescale 1ns/1ps
module tb_jtbubl_vtiming_rx;

    localparam int LF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic pxl_cen = 1'b0;
    logic LHBL = 1'b0, LVBL = 1'b0, HS = 1'b0, VS = 1'b0;
    logic [8:0] hcnt, vcnt, htotal, hactive, vtotal, vactive;
    logic [8:0] hs_pos, vs_line;
    logic line_start, frame_start, locked;

    jtbubl_vtiming_rx #(.LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .hcnt(hcnt), .vcnt(vcnt), .htotal(htotal), .hactive(hactive),
        .vtotal(vtotal), .vactive(vactive), .hs_pos(hs_pos),
        .vs_line(vs_line), .line_start(line_start),
        .frame_start(frame_start), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 511) ? 511 : x;
    endfunction

    // ---------------- reference model ----------------
    // Pixel and line counts are kept unbounded; outputs clamp them.
    int m_n, m_l, m_htot, m_hact, m_vtot, m_vact, m_hsp, m_vsl, m_match;
    int s_h, s_ha, s_v, s_va;
    bit m_hval, m_vval, m_hstab, m_ls, m_fs;
    bit p_lhbl, p_hs, p_vs, p_lvbl_line;

    task automatic m_reset();
        m_n = 0; m_l = 0; m_htot = 0; m_hact = 0; m_vtot = 0; m_vact = 0;
        m_hsp = 0; m_vsl = 0; m_match = 0;
        s_h = 0; s_ha = 0; s_v = 0; s_va = 0;
        m_hval = 0; m_vval = 0; m_hstab = 1; m_ls = 0; m_fs = 0;
        p_lhbl = 0; p_hs = 0; p_vs = 0; p_lvbl_line = 0;
    endtask

    task automatic m_step();
        bit rise, fall;
        m_ls = 0;
        m_fs = 0;
        if (pxl_cen) begin
            rise = LHBL && !p_lhbl;
            fall = !LHBL && p_lhbl;
            if (fall && m_hval) m_hact = sat(m_n + 1);
            if (rise) begin
                if (m_hval) begin
                    if (sat(m_n + 1) != m_htot) m_hstab = 0;
                    m_htot = sat(m_n + 1);
                end
                m_hval = 1;
                m_n = 0;
                m_ls = 1;
                if (LVBL && !p_lvbl_line) begin
                    m_fs = 1;
                    if (m_vval) begin
                        m_vtot = sat(m_l + 1);
                        if (m_hstab && m_htot == s_h && m_hact == s_ha &&
                            m_vtot == s_v && m_vact == s_va)
                            m_match = (m_match < LF) ? m_match + 1 : LF;
                        else
                            m_match = 0;
                        s_h = m_htot; s_ha = m_hact;
                        s_v = m_vtot; s_va = m_vact;
                        m_hstab = 1;
                    end
                    m_vval = 1;
                    m_l = 0;
                end else begin
                    if (!LVBL && p_lvbl_line && m_vval) m_vact = sat(m_l + 1);
                    m_l++;
                    if (m_l == 512) m_match = 0;
                end
                p_lvbl_line = LVBL;
            end else begin
                m_n++;
                if (m_n == 512) m_match = 0;
            end
            if (HS && !p_hs) m_hsp = sat(m_n);
            if (VS && !p_vs) m_vsl = sat(m_l);
            p_lhbl = LHBL;
            p_hs = HS;
            p_vs = VS;
        end
    endtask

    initial m_reset();

    // Compare on the falling edge, then advance the model with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst_n) m_reset();
        check("hcnt", int'(hcnt), sat(m_n));
        check("vcnt", int'(vcnt), sat(m_l));
        check("htotal", int'(htotal), m_htot);
        check("hactive", int'(hactive), m_hact);
        check("vtotal", int'(vtotal), m_vtot);
        check("vactive", int'(vactive), m_vact);
        check("hs_pos", int'(hs_pos), m_hsp);
        check("vs_line", int'(vs_line), m_vsl);
        check("line_start", int'(line_start), int'(m_ls));
        check("frame_start", int'(frame_start), int'(m_fs));
        check("locked", int'(locked), (m_match == LF) ? 1 : 0);
        if (rst_n) m_step();
    end

    // ---------------- pattern generator ----------------
    int gx = 0, gy = 0, ex = 0, ey = 0;
    int hlen, hact, vlen, vact, hs_at, vs_at, gap;
    bit stretch = 0, hold = 0, rnd = 0;

    task automatic cen_pixel();
        int len;
        len = hlen + (stretch ? 1 : 0);
        pxl_cen = 1'b1;
        LHBL = hold || (gx < hact);
        LVBL = (gy < vact);
        HS = (gx >= hs_at) && (gx < hs_at + 2);
        VS = (gy >= vs_at) && (gy < vs_at + 2);
        ex = gx;
        ey = gy;
        if (!hold) begin
            gx++;
            if (gx >= len) begin
                gx = 0;
                stretch = 0;
                gy++;
                if (gy >= vlen) gy = 0;
                if (rnd) begin
                    stretch = ($urandom_range(0, 5) == 0);
                    hs_at = $urandom_range(hact, hlen - 2);
                end
            end
        end
        @(posedge clk);
        #2;
        for (int i = 1; i < gap; i++) begin
            pxl_cen = 1'b0;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle(input int n);
        pxl_cen = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bound_hit(input string where);
        n_chk++;
        n_fail++;
        $display("FAIL %s: generator bound expired at %0t", where, $time);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "generator bound expired");
    endtask

    task automatic run_until(input int x, input int y);
        int guard;
        guard = 0;
        while (!(gx == x && gy == y)) begin
            cen_pixel();
            guard++;
            if (guard > 20000) bound_hit("run_until");
        end
    endtask

    task automatic run_frame();
        int guard;
        guard = 0;
        cen_pixel();
        while (!(ex == 0 && ey == 0)) begin
            cen_pixel();
            guard++;
            if (guard > 20000) bound_hit("run_frame");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        hlen = 12; hact = 8; vlen = 264; vact = 224;
        hs_at = 9; vs_at = 240; gap = 1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst hcnt", int'(hcnt), 0);
        check("rst htotal", int'(htotal), 0);
        check("rst locked", int'(locked), 0);
        rst_n = 1'b1;

        // Tall frames with short lines, cen every clock
        cen_pixel();
        check("first frame_start", int'(frame_start), 1);
        check("first htotal", int'(htotal), 0);
        run_frame();
        check("g1 htotal", int'(htotal), 12);
        check("g1 hactive", int'(hactive), 8);
        check("g1 vtotal", int'(vtotal), 264);
        check("g1 vactive", int'(vactive), 224);
        check("g1 vs_line", int'(vs_line), 240);
        check("g1 hs_pos", int'(hs_pos), 9);
        check("g1 locked fs2", int'(locked), 0);
        run_frame();
        check("g1 locked fs3", int'(locked), 0);
        run_frame();
        check("g1 locked fs4", int'(locked), 1);

        // Wide lines, short frames
        hlen = 384; hact = 256; vlen = 6; vact = 4;
        hs_at = 288; vs_at = 4; gap = 2;
        run_frame();
        run_frame();
        check("g2 htotal", int'(htotal), 384);
        check("g2 hactive", int'(hactive), 256);
        check("g2 vtotal", int'(vtotal), 6);
        check("g2 vactive", int'(vactive), 4);
        check("g2 hs_pos", int'(hs_pos), 288);
        check("g2 vs_line", int'(vs_line), 4);
        run_until(383, 1);
        gap = 1;
        cen_pixel();
        check("wrap hcnt 383", int'(hcnt), 383);
        cen_pixel();
        check("wrap hcnt 0", int'(hcnt), 0);
        check("wrap line_start", int'(line_start), 1);

        // Small frames, cen at 1/8 of clk; lock then stretch a line
        hlen = 24; hact = 16; vlen = 10; vact = 7;
        hs_at = 18; vs_at = 8; gap = 8;
        repeat (4) run_frame();
        check("g3 locked", int'(locked), 1);
        check("g3 htotal", int'(htotal), 24);
        check("g3 hactive", int'(hactive), 16);
        check("g3 vtotal", int'(vtotal), 10);
        check("g3 vactive", int'(vactive), 7);
        run_until(0, 3);
        stretch = 1;
        repeat (25) cen_pixel();
        cen_pixel();
        check("stretch htotal", int'(htotal), 25);
        check("stretch still locked", int'(locked), 1);
        run_frame();
        check("stretch unlock", int'(locked), 0);
        run_frame();
        check("relock fs1", int'(locked), 0);
        run_frame();
        check("relock fs2", int'(locked), 1);

        // Stuck LHBL: pixel counter saturates and lock drops
        run_until(5, 1);
        hold = 1;
        repeat (600) cen_pixel();
        check("hold hcnt", int'(hcnt), 511);
        check("hold locked", int'(locked), 0);
        hold = 0;
        gap = 1;
        run_frame();
        run_frame();

        // Reset during horizontal blank
        run_until(20, 2);
        pxl_cen = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid rst hcnt", int'(hcnt), 0);
        check("mid rst vcnt", int'(vcnt), 0);
        check("mid rst htotal", int'(htotal), 0);
        check("mid rst hactive", int'(hactive), 0);
        check("mid rst vtotal", int'(vtotal), 0);
        check("mid rst hs_pos", int'(hs_pos), 0);
        check("mid rst vs_line", int'(vs_line), 0);
        check("mid rst locked", int'(locked), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_until(0, 3);
        cen_pixel();
        check("post rst rise1 htotal", int'(htotal), 0);
        run_until(0, 4);
        cen_pixel();
        check("post rst rise2 htotal", int'(htotal), 24);

        // Pixel enable gated off mid-line
        run_until(10, 5);
        cen_pixel();
        idle(1000);
        check("gated hcnt", int'(hcnt), 10);
        check("gated htotal", int'(htotal), 24);
        check("gated hactive", int'(hactive), 16);

        // Random cen spacing, stretched lines and HS placement
        rnd = 1;
        repeat (4000) begin
            gap = $urandom_range(1, 3);
            cen_pixel();
            if ($urandom_range(0, 499) == 0) idle($urandom_range(1, 50));
        end
        rnd = 0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
